// File: rtl/mmio_router.sv
// Address decoder from the core data Membus to RAM and ACLINT, one transaction in flight.
// Slave responses are forwarded combinationally; unmapped accesses fault one cycle after accept.
module mmio_router #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE    = 'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] RAM_SIZE    = 'h0800_0000,
  parameter logic [ADDR_WIDTH-1:0] ACLINT_BASE = 'h0200_0000,
  parameter logic [ADDR_WIDTH-1:0] ACLINT_SIZE = 'h0001_0000
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_wen,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wmask,
  output logic                    req_rvalid,
  output logic [DATA_WIDTH-1:0]   req_rdata,
  output logic                    req_fault,

  output logic                    ram_valid,
  input  logic                    ram_ready,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic                    ram_wen,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic [DATA_WIDTH/8-1:0] ram_wmask,
  input  logic                    ram_rvalid,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,

  output logic                    aclint_valid,
  input  logic                    aclint_ready,
  output logic [ADDR_WIDTH-1:0]   aclint_addr,
  output logic                    aclint_wen,
  output logic [DATA_WIDTH-1:0]   aclint_wdata,
  output logic [DATA_WIDTH/8-1:0] aclint_wmask,
  input  logic                    aclint_rvalid,
  input  logic [DATA_WIDTH-1:0]   aclint_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RAM,
    WAIT_ACLINT,
    WAIT_ERR
  } state_t;

  state_t state_q, state_d;

  // Region ends carry one extra bit so a region touching 2^AW does not wrap to zero.
  localparam logic [ADDR_WIDTH:0] RAM_END    = {1'b0, RAM_BASE} + {1'b0, RAM_SIZE};
  localparam logic [ADDR_WIDTH:0] ACLINT_END = {1'b0, ACLINT_BASE} + {1'b0, ACLINT_SIZE};

  logic hit_ram;
  logic hit_aclint;

  assign hit_ram    = (req_addr >= RAM_BASE) && ({1'b0, req_addr} < RAM_END);
  assign hit_aclint = (req_addr >= ACLINT_BASE) && ({1'b0, req_addr} < ACLINT_END);

  assign ram_addr     = req_addr;
  assign ram_wen      = req_wen;
  assign ram_wdata    = req_wdata;
  assign ram_wmask    = req_wmask;
  assign aclint_addr  = req_addr;
  assign aclint_wen   = req_wen;
  assign aclint_wdata = req_wdata;
  assign aclint_wmask = req_wmask;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ram_valid    = 1'b0;
    aclint_valid = 1'b0;
    req_ready    = 1'b0;
    req_rvalid   = 1'b0;
    req_rdata    = '0;
    req_fault    = 1'b0;

    unique case (state_q)
      IDLE: begin
        ram_valid    = req_valid & hit_ram;
        aclint_valid = req_valid & hit_aclint;
        if (hit_ram) begin
          req_ready = ram_ready;
        end else if (hit_aclint) begin
          req_ready = aclint_ready;
        end else begin
          req_ready = 1'b1;
        end
        if (req_valid && req_ready) begin
          if (hit_ram) begin
            state_d = WAIT_RAM;
          end else if (hit_aclint) begin
            state_d = WAIT_ACLINT;
          end else begin
            state_d = WAIT_ERR;
          end
        end
      end
      WAIT_RAM: begin
        if (ram_rvalid) begin
          req_rvalid = 1'b1;
          req_rdata  = ram_rdata;
          state_d    = IDLE;
        end
      end
      WAIT_ACLINT: begin
        if (aclint_rvalid) begin
          req_rvalid = 1'b1;
          req_rdata  = aclint_rdata;
          state_d    = IDLE;
        end
      end
      WAIT_ERR: begin
        req_rvalid = 1'b1;
        req_fault  = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mmio_router.sv
// Directed bench for mmio_router: routing, responses, faults, stalls, spurious responses, reset.
module tb_mmio_router;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        req_rvalid;
  logic [63:0] req_rdata;
  logic        req_fault;
  logic        ram_valid;
  logic        ram_ready;
  logic [63:0] ram_addr;
  logic        ram_wen;
  logic [63:0] ram_wdata;
  logic [7:0]  ram_wmask;
  logic        ram_rvalid;
  logic [63:0] ram_rdata;
  logic        aclint_valid;
  logic        aclint_ready;
  logic [63:0] aclint_addr;
  logic        aclint_wen;
  logic [63:0] aclint_wdata;
  logic [7:0]  aclint_wmask;
  logic        aclint_rvalid;
  logic [63:0] aclint_rdata;

  int n_pass;
  int n_total;

  mmio_router dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wen      (req_wen),
    .req_wdata    (req_wdata),
    .req_wmask    (req_wmask),
    .req_rvalid   (req_rvalid),
    .req_rdata    (req_rdata),
    .req_fault    (req_fault),
    .ram_valid    (ram_valid),
    .ram_ready    (ram_ready),
    .ram_addr     (ram_addr),
    .ram_wen      (ram_wen),
    .ram_wdata    (ram_wdata),
    .ram_wmask    (ram_wmask),
    .ram_rvalid   (ram_rvalid),
    .ram_rdata    (ram_rdata),
    .aclint_valid (aclint_valid),
    .aclint_ready (aclint_ready),
    .aclint_addr  (aclint_addr),
    .aclint_wen   (aclint_wen),
    .aclint_wdata (aclint_wdata),
    .aclint_wmask (aclint_wmask),
    .aclint_rvalid(aclint_rvalid),
    .aclint_rdata (aclint_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req_valid = 1'b0;
    req_addr = 64'h0;
    ram_rvalid = 1'b1;
    ram_rdata = 64'h1111;
    tick();
    tick();
    #1;
    n_total++; if (req_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %0h want 0", req_rvalid); else n_pass++;
    n_total++; if (req_fault !== 1'b0) $display("FAIL rst_fault: got %0h want 0", req_fault); else n_pass++;
    n_total++; if (req_rdata !== 64'h0) $display("FAIL rst_rdata: got %0h want 0", req_rdata); else n_pass++;
    n_total++; if (ram_valid !== 1'b0 || aclint_valid !== 1'b0)
      $display("FAIL rst_slave_valid: got ram=%0h aclint=%0h want 0/0", ram_valid, aclint_valid); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL rst_ready_unmapped: got %0h want 1", req_ready); else n_pass++;
    ram_rvalid = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ram_read;
    req_valid = 1'b1;
    req_addr = 64'h8000_0010;
    req_wen = 1'b0;
    ram_ready = 1'b1;
    #1;
    n_total++; if (ram_valid !== 1'b1 || aclint_valid !== 1'b0)
      $display("FAIL rd_route: got ram=%0h aclint=%0h want 1/0", ram_valid, aclint_valid); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL rd_ready: got %0h want 1", req_ready); else n_pass++;
    n_total++; if (ram_addr !== 64'h8000_0010) $display("FAIL rd_addr: got %0h want 80000010", ram_addr); else n_pass++;
    tick();
    req_valid = 1'b0;
    #1;
    n_total++; if (req_rvalid !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL rd_wait: got rvalid=%0h ready=%0h want 0/0", req_rvalid, req_ready); else n_pass++;
    tick();
    ram_rvalid = 1'b1;
    ram_rdata = 64'hDEAD_BEEF;
    #1;
    n_total++; if (req_rvalid !== 1'b1) $display("FAIL rd_rvalid: got %0h want 1", req_rvalid); else n_pass++;
    n_total++; if (req_rdata !== 64'hDEAD_BEEF) $display("FAIL rd_rdata: got %0h want deadbeef", req_rdata); else n_pass++;
    n_total++; if (req_fault !== 1'b0) $display("FAIL rd_fault: got %0h want 0", req_fault); else n_pass++;
    n_total++; if (req_ready !== 1'b0) $display("FAIL rd_no_b2b: got %0h want 0", req_ready); else n_pass++;
    tick();
    ram_rvalid = 1'b0;
    #1;
    n_total++; if (req_rvalid !== 1'b0 || req_rdata !== 64'h0)
      $display("FAIL rd_after: got rvalid=%0h rdata=%0h want 0/0", req_rvalid, req_rdata); else n_pass++;
  endtask

  task automatic test_aclint_write;
    req_valid = 1'b1;
    req_addr = 64'h0200_4000;
    req_wen = 1'b1;
    req_wdata = 64'h64;
    req_wmask = 8'hFF;
    aclint_ready = 1'b1;
    #1;
    n_total++; if (aclint_valid !== 1'b1 || ram_valid !== 1'b0)
      $display("FAIL wr_route: got aclint=%0h ram=%0h want 1/0", aclint_valid, ram_valid); else n_pass++;
    n_total++; if (aclint_wdata !== 64'h64 || aclint_wmask !== 8'hFF || aclint_wen !== 1'b1)
      $display("FAIL wr_pass: got wdata=%0h wmask=%0h wen=%0h want 64/ff/1", aclint_wdata, aclint_wmask, aclint_wen); else n_pass++;
    tick();
    req_valid = 1'b0;
    aclint_rvalid = 1'b1;
    aclint_rdata = 64'h0;
    #1;
    n_total++; if (req_rvalid !== 1'b1 || req_fault !== 1'b0)
      $display("FAIL wr_resp: got rvalid=%0h fault=%0h want 1/0", req_rvalid, req_fault); else n_pass++;
    n_total++; if (ram_valid !== 1'b0) $display("FAIL wr_ram_quiet: got %0h want 0", ram_valid); else n_pass++;
    tick();
    aclint_rvalid = 1'b0;
    req_wen = 1'b0;
    #1;
    n_total++; if (req_rvalid !== 1'b0) $display("FAIL wr_single_resp: got %0h want 0", req_rvalid); else n_pass++;
  endtask

  task automatic test_unmapped;
    ram_ready = 1'b0;
    aclint_ready = 1'b0;
    ram_rdata = 64'h55AA;
    req_valid = 1'b1;
    req_addr = 64'h1000_0000;
    #1;
    n_total++; if (req_ready !== 1'b1) $display("FAIL um_ready: got %0h want 1", req_ready); else n_pass++;
    n_total++; if (ram_valid !== 1'b0 || aclint_valid !== 1'b0)
      $display("FAIL um_no_slave: got ram=%0h aclint=%0h want 0/0", ram_valid, aclint_valid); else n_pass++;
    tick();
    req_valid = 1'b0;
    #1;
    n_total++; if (req_rvalid !== 1'b1 || req_fault !== 1'b1)
      $display("FAIL um_resp: got rvalid=%0h fault=%0h want 1/1", req_rvalid, req_fault); else n_pass++;
    n_total++; if (req_rdata !== 64'h0) $display("FAIL um_rdata: got %0h want 0", req_rdata); else n_pass++;
    tick();
    #1;
    n_total++; if (req_rvalid !== 1'b0 || req_fault !== 1'b0)
      $display("FAIL um_one_cycle: got rvalid=%0h fault=%0h want 0/0", req_rvalid, req_fault); else n_pass++;
  endtask

  task automatic test_ram_stall;
    ram_ready = 1'b0;
    req_valid = 1'b1;
    req_addr = 64'h8000_0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++; if (req_ready !== 1'b0 || ram_valid !== 1'b1)
        $display("FAIL stall_cyc%0d: got ready=%0h ram_valid=%0h want 0/1", i, req_ready, ram_valid); else n_pass++;
      tick();
    end
    ram_ready = 1'b1;
    #1;
    n_total++; if (req_ready !== 1'b1) $display("FAIL stall_accept: got %0h want 1", req_ready); else n_pass++;
    tick();
    #1;
    n_total++; if (ram_valid !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL stall_no_dup: got ram_valid=%0h ready=%0h want 0/0", ram_valid, req_ready); else n_pass++;
    req_valid = 1'b0;
    tick();
    ram_rvalid = 1'b1;
    ram_rdata = 64'h1234;
    #1;
    n_total++; if (req_rvalid !== 1'b1 || req_rdata !== 64'h1234)
      $display("FAIL stall_resp: got rvalid=%0h rdata=%0h want 1/1234", req_rvalid, req_rdata); else n_pass++;
    tick();
    ram_rvalid = 1'b0;
  endtask

  task automatic test_spurious;
    req_valid = 1'b0;
    aclint_rvalid = 1'b1;
    aclint_rdata = 64'hBAD;
    #1;
    n_total++; if (req_rvalid !== 1'b0 || req_rdata !== 64'h0)
      $display("FAIL spur_idle: got rvalid=%0h rdata=%0h want 0/0", req_rvalid, req_rdata); else n_pass++;
    tick();
    aclint_rvalid = 1'b0;
    req_valid = 1'b1;
    req_addr = 64'h8000_0020;
    ram_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    aclint_rvalid = 1'b1;
    #1;
    n_total++; if (req_rvalid !== 1'b0) $display("FAIL spur_wait_ram: got %0h want 0", req_rvalid); else n_pass++;
    tick();
    aclint_rvalid = 1'b0;
    ram_rvalid = 1'b1;
    ram_rdata = 64'hCAFE;
    #1;
    n_total++; if (req_rvalid !== 1'b1 || req_rdata !== 64'hCAFE || req_fault !== 1'b0)
      $display("FAIL spur_ram_resp: got rvalid=%0h rdata=%0h fault=%0h want 1/cafe/0", req_rvalid, req_rdata, req_fault); else n_pass++;
    tick();
    ram_rvalid = 1'b0;
  endtask

  task automatic test_reset_mid;
    req_valid = 1'b1;
    req_addr = 64'h8000_0030;
    ram_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    ram_rvalid = 1'b1;
    ram_rdata = 64'h77;
    #1;
    n_total++; if (req_rvalid !== 1'b0) $display("FAIL rstmid_late_rvalid: got %0h want 0", req_rvalid); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL rstmid_idle: got %0h want 1", req_ready); else n_pass++;
    tick();
    ram_rvalid = 1'b0;
  endtask

  task automatic test_edges;
    req_valid = 1'b1;
    req_addr = 64'h87FF_FFF8;
    ram_ready = 1'b1;
    #1;
    n_total++; if (ram_valid !== 1'b1) $display("FAIL edge_ram_last: got %0h want 1", ram_valid); else n_pass++;
    tick();
    req_valid = 1'b0;
    ram_rvalid = 1'b1;
    ram_rdata = 64'h0F;
    #1;
    n_total++; if (req_rvalid !== 1'b1 || req_fault !== 1'b0 || req_rdata !== 64'h0F)
      $display("FAIL edge_ram_resp: got rvalid=%0h fault=%0h rdata=%0h want 1/0/f", req_rvalid, req_fault, req_rdata); else n_pass++;
    tick();
    ram_rvalid = 1'b0;
    req_valid = 1'b1;
    req_addr = 64'h8800_0000;
    ram_ready = 1'b0;
    #1;
    n_total++; if (ram_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL edge_ram_end: got ram_valid=%0h ready=%0h want 0/1", ram_valid, req_ready); else n_pass++;
    tick();
    req_valid = 1'b0;
    #1;
    n_total++; if (req_rvalid !== 1'b1 || req_fault !== 1'b1)
      $display("FAIL edge_end_fault: got rvalid=%0h fault=%0h want 1/1", req_rvalid, req_fault); else n_pass++;
    tick();
    req_valid = 1'b1;
    req_addr = 64'h7FFF_FFF8;
    #1;
    n_total++; if (ram_valid !== 1'b0) $display("FAIL edge_below_ram: got %0h want 0", ram_valid); else n_pass++;
    req_addr = 64'h0200_FFF8;
    aclint_ready = 1'b0;
    #1;
    n_total++; if (aclint_valid !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL edge_aclint_last: got valid=%0h ready=%0h want 1/0", aclint_valid, req_ready); else n_pass++;
    req_addr = 64'h0201_0000;
    #1;
    n_total++; if (aclint_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL edge_aclint_end: got valid=%0h ready=%0h want 0/1", aclint_valid, req_ready); else n_pass++;
    req_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_wen = 1'b0;
    req_wdata = '0;
    req_wmask = '0;
    ram_ready = 1'b0;
    ram_rvalid = 1'b0;
    ram_rdata = '0;
    aclint_ready = 1'b0;
    aclint_rvalid = 1'b0;
    aclint_rdata = '0;

    test_reset();
    test_ram_read();
    test_aclint_write();
    test_unmapped();
    test_ram_stall();
    test_spurious();
    test_reset_mid();
    test_edges();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
